// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared types and helpers for the SRAM port master.
// Holds the pipeline tag type that follows each credited request through
// the macro's fixed read latency, and the counter-width helper.
package sram_port_pkg;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // One slot of the read-latency pipeline.
  typedef struct packed {
    logic valid;     // a credited request occupies this slot
    logic is_write;  // slot belongs to a write ack, not a read
  } pipe_tag_t;

  localparam pipe_tag_t PIPE_TAG_IDLE = '{valid: 1'b0, is_write: 1'b0};

endpackage

// File: rtl/sram_port_master_chk.sv
// sram_port_master_chk: invariants of the credit scheme. The credit counter
// must never exceed the buffer depth, and the response buffer must never be
// pushed while full (credits exist precisely to prevent that).
module sram_port_master_chk #(
  parameter int unsigned CW        = 2,
  parameter int unsigned RSP_DEPTH = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          push_i,
  input logic          full_i,
  input logic [CW-1:0] used_i
);

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(push_i && full_i)
  );

  a_used_bounded: assert property (
    @(posedge clk_i) disable iff (!rst_ni) used_i <= CW'(RSP_DEPTH)
  );

endmodule

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: registered circular response buffer.
// Output data is read straight from the storage array and forced to zero
// while the buffer is empty, so the response data port is quiet when idle.
module sram_rsp_fifo
  import sram_port_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_s, pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the buffer and clears its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_port_master.sv
// sram_port_master: valid/ready request stream to single-port SRAM macro.
// Reads (and writes, when SRAM_PORT_MASTER_WR_ACK_EN is defined) take a
// credit at accept; the credit returns when the response is popped. Since
// credits cover both the read pipeline and the response buffer, returned
// data always has a slot and upstream back-pressure never loses data.
// Optional feature macro: SRAM_PORT_MASTER_WR_ACK_EN (write ack responses).
module sram_port_master
  import sram_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 3,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned CW = cnt_width(RSP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic                  needs_credit_s;
  logic                  accept_s;
  logic                  credit_acc_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic [CW-1:0]         used_q, used_d;
  pipe_tag_t             pipe_q [READ_LATENCY];
  pipe_tag_t             pipe_d [READ_LATENCY];
  pipe_tag_t             exit_s;

`ifdef SRAM_PORT_MASTER_WR_ACK_EN
  assign needs_credit_s = 1'b1;
`else
  assign needs_credit_s = ~req_we_i;
`endif

  // Ready depends only on the credit register and the request type.
  assign req_ready_o  = ~needs_credit_s | (used_q < DEPTH_C);
  assign accept_s     = req_valid_i & req_ready_o;
  assign credit_acc_s = accept_s & needs_credit_s;

  // Request fields go straight to the macro; only the strobe is gated.
  assign sram_req_o   = accept_s;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // The last pipeline slot lines up with valid macro read data.
  assign exit_s      = pipe_q[READ_LATENCY-1];
  assign push_s      = exit_s.valid;
  assign push_data_s = exit_s.is_write ? '0 : sram_rdata_i;

  assign rsp_valid_o = ~fifo_empty_s;
  assign pop_s       = rsp_valid_o & rsp_ready_i;

  // Shift credited requests through the read-latency pipeline.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = '{valid: credit_acc_s, is_write: credit_acc_s & req_we_i};
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Credit count: take on credited accept, return on pop.
  always_comb begin
    used_d = used_q;
    case ({credit_acc_s, pop_s})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase
  end

  // Pipeline and credit registers; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= PIPE_TAG_IDLE;
      end
      used_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      used_q <= used_d;
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .data_o  (rsp_rdata_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  sram_port_master_chk #(
    .CW        (CW),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_s),
    .full_i (fifo_full_s),
    .used_i (used_q)
  );

endmodule
